// File: rtl/operand_forward_reg.sv
// ID/EX operand stage: per-source forwarding from DEPTH producer stages, load-use interlock, hold/flush.
// Optional forward/stall statistics counters are built when FWD_STAT_EN is defined.
module operand_forward_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
    input  logic [NUM_SRC*DATA_W-1:0] id_data_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic                      id_we_i,
    input  logic                      id_ld_i,
    input  logic [DEPTH*REG_AW-1:0]   fwd_rd_i,
    input  logic [DEPTH-1:0]          fwd_we_i,
    input  logic [DEPTH-1:0]          fwd_pend_i,
    input  logic [DEPTH*DATA_W-1:0]   fwd_data_i,
    input  logic                      hold_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic                      ex_valid_o,
    output logic [NUM_SRC*DATA_W-1:0] ex_data_o,
    output logic [REG_AW-1:0]         ex_rd_o,
    output logic                      ex_we_o,
    output logic                      ex_ld_o,
    output logic [31:0]               fwd_cnt_o,
    output logic [31:0]               stall_cnt_o
);

    logic [NUM_SRC*DATA_W-1:0] sel_data;
    logic [NUM_SRC-1:0]        op_haz;
    logic                      ex_load;
    logic                      hazard;
`ifdef FWD_STAT_EN
    logic [NUM_SRC-1:0]        fwd_hit;
`endif

    assign ex_load = ex_valid_o & ex_we_o & ex_ld_o;

    // NOTE: every variable gets a default before the loops so no latch can be inferred.
    always_comb begin
        sel_data = id_data_i;
        op_haz   = '0;
`ifdef FWD_STAT_EN
        fwd_hit  = '0;
`endif
        for (int n = 0; n < NUM_SRC; n++) begin
            // Walk oldest to nearest so the nearest match (and its pending flag) wins.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (fwd_we_i[k] &&
                    id_rs_i[n*REG_AW +: REG_AW] != '0 &&
                    fwd_rd_i[k*REG_AW +: REG_AW] == id_rs_i[n*REG_AW +: REG_AW]) begin
                    sel_data[n*DATA_W +: DATA_W] = fwd_data_i[k*DATA_W +: DATA_W];
                    op_haz[n]                    = fwd_pend_i[k];
`ifdef FWD_STAT_EN
                    fwd_hit[n]                   = 1'b1;
`endif
                end
            end
            if (ex_load && id_rs_i[n*REG_AW +: REG_AW] != '0 &&
                ex_rd_o == id_rs_i[n*REG_AW +: REG_AW]) begin
                op_haz[n] = 1'b1;
            end
        end
    end

    assign hazard  = id_valid_i & (|op_haz);
    assign stall_o = hazard | hold_i;

    // NOTE: non-blocking assignments so all EX registers update from pre-edge values together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_o <= 1'b0;
            ex_data_o  <= '0;
            ex_rd_o    <= '0;
            ex_we_o    <= 1'b0;
            ex_ld_o    <= 1'b0;
        end else if (!hold_i) begin
            if (flush_i || hazard) begin
                ex_valid_o <= 1'b0;
                ex_we_o    <= 1'b0;
                ex_ld_o    <= 1'b0;
            end else begin
                ex_valid_o <= id_valid_i;
                ex_data_o  <= sel_data;
                ex_rd_o    <= id_rd_i;
                ex_we_o    <= id_we_i & id_valid_i;
                ex_ld_o    <= id_ld_i & id_valid_i;
            end
        end
    end

`ifdef FWD_STAT_EN
    logic [31:0] fwd_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] nfwd;
    logic [32:0] fwd_sum;
    logic        capture;

    always_comb begin
        nfwd = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            nfwd = nfwd + 32'(fwd_hit[n]);
        end
    end

    assign fwd_sum = {1'b0, fwd_cnt_q} + {1'b0, nfwd};
    assign capture = !hold_i && !flush_i && !hazard && id_valid_i;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (capture) begin
                fwd_cnt_q <= fwd_sum[32] ? '1 : fwd_sum[31:0];
            end
            if (hazard && !hold_i && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fwd_cnt_o   = fwd_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign fwd_cnt_o   = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_operand_forward_reg.sv
// Self-checking bench for operand_forward_reg: directed plan steps, then random traffic against a reference model.
`timescale 1ns/1ps
module tb_operand_forward_reg;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 2;
`ifdef FWD_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic                      clk_i;
    logic                      rst_i;
    logic                      id_valid_i;
    logic [NUM_SRC*REG_AW-1:0] id_rs_i;
    logic [NUM_SRC*DATA_W-1:0] id_data_i;
    logic [REG_AW-1:0]         id_rd_i;
    logic                      id_we_i;
    logic                      id_ld_i;
    logic [DEPTH*REG_AW-1:0]   fwd_rd_i;
    logic [DEPTH-1:0]          fwd_we_i;
    logic [DEPTH-1:0]          fwd_pend_i;
    logic [DEPTH*DATA_W-1:0]   fwd_data_i;
    logic                      hold_i;
    logic                      flush_i;
    logic                      stall_o;
    logic                      ex_valid_o;
    logic [NUM_SRC*DATA_W-1:0] ex_data_o;
    logic [REG_AW-1:0]         ex_rd_o;
    logic                      ex_we_o;
    logic                      ex_ld_o;
    logic [31:0]               fwd_cnt_o;
    logic [31:0]               stall_cnt_o;

    operand_forward_reg #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_data_i(id_data_i),
        .id_rd_i(id_rd_i), .id_we_i(id_we_i), .id_ld_i(id_ld_i),
        .fwd_rd_i(fwd_rd_i), .fwd_we_i(fwd_we_i), .fwd_pend_i(fwd_pend_i),
        .fwd_data_i(fwd_data_i), .hold_i(hold_i), .flush_i(flush_i),
        .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_data_o(ex_data_o),
        .ex_rd_o(ex_rd_o), .ex_we_o(ex_we_o), .ex_ld_o(ex_ld_o),
        .fwd_cnt_o(fwd_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: architectural EX contents and statistics.
    logic              m_valid = 1'b0;
    logic              m_we    = 1'b0;
    logic              m_ld    = 1'b0;
    logic [REG_AW-1:0] m_rd    = '0;
    logic [DATA_W-1:0] m_data [NUM_SRC];
    longint            m_fwd_cnt   = 0;
    longint            m_stall_cnt = 0;
    logic              exp_stall;
    logic              exp_hazard;
    logic [DATA_W-1:0] exp_sel [NUM_SRC];
    int                exp_nfwd;
    logic              obs_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REG_AW-1:0] rs_of(input int n);
        return id_rs_i[n*REG_AW +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] prod_rd(input int k);
        return fwd_rd_i[k*REG_AW +: REG_AW];
    endfunction

    // Hazard and operand choice derived straight from the forwarding rules.
    task automatic model_comb();
        bit haz;
        int youngest;
        haz      = 1'b0;
        exp_nfwd = 0;
        for (int n = 0; n < NUM_SRC; n++) begin
            exp_sel[n] = id_data_i[n*DATA_W +: DATA_W];
            if (rs_of(n) != 0) begin
                youngest = -1;
                for (int k = 0; k < DEPTH; k++) begin
                    if (youngest < 0 && fwd_we_i[k] && prod_rd(k) == rs_of(n)) youngest = k;
                end
                if (youngest >= 0) begin
                    exp_sel[n] = fwd_data_i[youngest*DATA_W +: DATA_W];
                    exp_nfwd++;
                    if (fwd_pend_i[youngest]) haz = 1'b1;
                end
                if (m_valid && m_we && m_ld && m_rd == rs_of(n)) haz = 1'b1;
            end
        end
        exp_hazard = id_valid_i && haz;
        exp_stall  = exp_hazard || hold_i;
    endtask

    task automatic model_next();
        if (rst_i) begin
            m_valid = 0; m_we = 0; m_ld = 0; m_rd = '0;
            for (int n = 0; n < NUM_SRC; n++) m_data[n] = '0;
            m_fwd_cnt = 0; m_stall_cnt = 0;
        end else begin
            if (STAT_EN && exp_hazard && !hold_i && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
            if (STAT_EN && !hold_i && !flush_i && !exp_hazard && id_valid_i) begin
                m_fwd_cnt = m_fwd_cnt + exp_nfwd;
                if (m_fwd_cnt > 64'hFFFF_FFFF) m_fwd_cnt = 64'hFFFF_FFFF;
            end
            if (!hold_i) begin
                if (flush_i || exp_hazard) begin
                    m_valid = 0; m_we = 0; m_ld = 0;
                end else begin
                    m_valid = id_valid_i;
                    m_we    = id_we_i && id_valid_i;
                    m_ld    = id_ld_i && id_valid_i;
                    m_rd    = id_rd_i;
                    for (int n = 0; n < NUM_SRC; n++) m_data[n] = exp_sel[n];
                end
            end
        end
    endtask

    task automatic compare_state(input string tag);
        check({tag, ".valid"}, 64'(ex_valid_o), 64'(m_valid));
        check({tag, ".we"}, 64'(ex_we_o), 64'(m_we));
        check({tag, ".ld"}, 64'(ex_ld_o), 64'(m_ld));
        if (m_valid) begin
            check({tag, ".rd"}, 64'(ex_rd_o), 64'(m_rd));
            for (int n = 0; n < NUM_SRC; n++)
                check({tag, ".data"}, 64'(ex_data_o[n*DATA_W +: DATA_W]), 64'(m_data[n]));
        end
        check({tag, ".fwd_cnt"}, 64'(fwd_cnt_o), 64'(m_fwd_cnt));
        check({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(m_stall_cnt));
    endtask

    // One clock: stall sampled mid-cycle, registered state sampled just after the edge.
    task automatic step(input string tag);
        @(negedge clk_i);
        model_comb();
        obs_stall = stall_o;
        check({tag, ".stall"}, 64'(stall_o), 64'(exp_stall));
        model_next();
        @(posedge clk_i);
        #1;
        compare_state(tag);
    endtask

    task automatic clear_inputs();
        id_valid_i = 0; id_rs_i = '0; id_data_i = '0; id_rd_i = '0;
        id_we_i = 0; id_ld_i = 0; fwd_rd_i = '0; fwd_we_i = '0;
        fwd_pend_i = '0; fwd_data_i = '0; hold_i = 0; flush_i = 0;
    endtask

    initial begin
        for (int n = 0; n < NUM_SRC; n++) m_data[n] = '0;
        clear_inputs();
        rst_i = 1;
        step("reset");
        step("reset");
        check("reset.data", 64'(ex_data_o), 64'd0);
        check("reset.rd", 64'(ex_rd_o), 64'd0);
        rst_i = 0;

        // Nearest-stage forward of operand 0.
        clear_inputs();
        id_valid_i = 1; id_rs_i[4:0] = 5'd3; fwd_we_i = 2'b01;
        fwd_rd_i[4:0] = 5'd3; fwd_data_i[31:0] = 32'hAAAA0001;
        step("fwd0");
        check("fwd0.exdata", 64'(ex_data_o[31:0]), 64'h0000_0000_AAAA_0001);
        check("fwd0.exvalid", 64'(ex_valid_o), 64'd1);
        check("fwd0.nostall", 64'(obs_stall), 64'd0);

        // Both stages write r7: the nearer one wins; r0 never forwards.
        clear_inputs();
        id_valid_i = 1; fwd_we_i = 2'b11;
        fwd_rd_i[4:0] = 5'd7; fwd_rd_i[9:5] = 5'd7;
        fwd_data_i[31:0] = 32'h11; fwd_data_i[63:32] = 32'h22;
        id_rs_i[9:5] = 5'd7; id_data_i[63:32] = 32'hCAFE;
        step("prio");
        check("prio.exdata1", 64'(ex_data_o[63:32]), 64'h11);
        id_rs_i[9:5] = 5'd0;
        step("prio_r0");
        check("prio_r0.exdata1", 64'(ex_data_o[63:32]), 64'hCAFE);

        // Load then dependent: exactly one bubble.
        clear_inputs();
        id_valid_i = 1; id_we_i = 1; id_ld_i = 1; id_rd_i = 5'd5;
        step("lu_load");
        clear_inputs();
        id_valid_i = 1; id_rs_i[4:0] = 5'd5; id_we_i = 1; id_rd_i = 5'd6;
        step("lu_dep");
        check("lu_dep.stall", 64'(obs_stall), 64'd1);
        check("lu_dep.bubble", 64'(ex_valid_o), 64'd0);
        fwd_we_i = 2'b01; fwd_rd_i[4:0] = 5'd5; fwd_data_i[31:0] = 32'h55;
        step("lu_go");
        check("lu_go.exdata", 64'(ex_data_o[31:0]), 64'h55);
        check("lu_go.stall", 64'(obs_stall), 64'd0);

        // Hold outranks flush.
        clear_inputs();
        id_valid_i = 1; id_data_i[31:0] = 32'h1234;
        step("hf_fill");
        hold_i = 1; flush_i = 1; id_data_i[31:0] = 32'h9999;
        step("hf_hold");
        check("hf_hold.exdata", 64'(ex_data_o[31:0]), 64'h1234);
        check("hf_hold.stall", 64'(obs_stall), 64'd1);
        hold_i = 0;
        step("hf_flush");
        check("hf_flush.exvalid", 64'(ex_valid_o), 64'd0);

        // Reset while a load-use stall is active.
        clear_inputs();
        id_valid_i = 1; id_we_i = 1; id_ld_i = 1; id_rd_i = 5'd9;
        step("rs_load");
        clear_inputs();
        id_valid_i = 1; id_rs_i[4:0] = 5'd9; rst_i = 1;
        step("rs_mid");
        check("rs_mid.stall", 64'(obs_stall), 64'd1);
        check("rs_mid.exvalid", 64'(ex_valid_o), 64'd0);
        check("rs_mid.fwd_cnt0", 64'(fwd_cnt_o), 64'd0);
        rst_i = 0;
        step("rs_after");
        check("rs_after.stall", 64'(obs_stall), 64'd0);

        // Statistics: three dual forwards plus one load-use stall.
        clear_inputs();
        rst_i = 1;
        step("st_rst");
        rst_i = 0;
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            id_valid_i = 1; id_rs_i[4:0] = 5'd1; id_rs_i[9:5] = 5'd2;
            fwd_we_i = 2'b11; fwd_rd_i[4:0] = 5'd1; fwd_rd_i[9:5] = 5'd2;
            fwd_data_i = {32'(i + 100), 32'(i + 200)};
            step("st_fwd");
        end
        clear_inputs();
        id_valid_i = 1; id_we_i = 1; id_ld_i = 1; id_rd_i = 5'd9;
        step("st_load");
        clear_inputs();
        id_valid_i = 1; id_rs_i[4:0] = 5'd9;
        step("st_dep");
        clear_inputs();
        step("st_idle");
        check("stat.fwd_cnt", 64'(fwd_cnt_o), STAT_EN ? 64'd6 : 64'd0);
        check("stat.stall_cnt", 64'(stall_cnt_o), STAT_EN ? 64'd1 : 64'd0);

        // Random traffic over a small register range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            id_valid_i = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < NUM_SRC; n++) begin
                id_rs_i[n*REG_AW +: REG_AW]   = REG_AW'($urandom_range(0, 3));
                id_data_i[n*DATA_W +: DATA_W] = $urandom;
            end
            id_rd_i = REG_AW'($urandom_range(0, 3));
            id_we_i = 1'($urandom_range(0, 1));
            id_ld_i = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < DEPTH; k++) begin
                fwd_rd_i[k*REG_AW +: REG_AW]   = REG_AW'($urandom_range(0, 3));
                fwd_we_i[k]                    = 1'($urandom_range(0, 1));
                fwd_pend_i[k]                  = ($urandom_range(0, 5) == 0);
                fwd_data_i[k*DATA_W +: DATA_W] = $urandom;
            end
            hold_i  = ($urandom_range(0, 9) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            rst_i   = ($urandom_range(0, 49) == 0);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_forward_reg.md
Name: operand_forward_reg

Overview:
- Parametrised ID/EX operand stage.
- For each of NUM_SRC source operands, compares the ID-stage source register against DEPTH downstream producer stages. It selects the youngest matching producer's data, or the register-file data if none match.
- Registers the result into the EX stage.
- Detects load-use hazards, inserts bubbles, and honours global hold and flush.
- Sits between the register file / decode and the ALU, replacing the fixed two-source forwarding muxes.

Parameters:
- DATA_W, 32, operand width.
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction.
- DEPTH, 2, producer stages visible for forwarding. Index 0 is nearest (EX/MEM), DEPTH-1 is oldest (MEM/WB).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- id_valid_i  in  1  ID instruction valid.
- id_rs_i  in  NUM_SRC*REG_AW  source register numbers; operand n at [n*REG_AW +: REG_AW].
- id_data_i  in  NUM_SRC*DATA_W  register-file read data.
- id_rd_i  in  REG_AW  destination register of ID instruction.
- id_we_i  in  1  ID instruction writes rd.
- id_ld_i  in  1  ID instruction is a load.
- fwd_rd_i  in  DEPTH*REG_AW  destination register per producer stage.
- fwd_we_i  in  DEPTH  producer writes rd.
- fwd_pend_i  in  DEPTH  producer result not yet available (load still in flight).
- fwd_data_i  in  DEPTH*DATA_W  producer result.
- hold_i  in  1  freeze (e.g. cache miss).
- flush_i  in  1  squash ID instruction (branch taken).
- stall_o  out  1  ID/IF must hold this cycle.
- ex_valid_o  out  1  EX instruction valid.
- ex_data_o  out  NUM_SRC*DATA_W  forwarded operands.
- ex_rd_o  out  REG_AW  EX destination.
- ex_we_o  out  1  EX write enable.
- ex_ld_o  out  1  EX is a load.
- fwd_cnt_o  out  32  forward event count (see Optional Feature).
- stall_cnt_o  out  32  hazard stall count (see Optional Feature).

Behaviour:
- Reset: every output register is 0. The counters are 0.
- Producer k matches operand n when all hold:
  - fwd_we_i[k] = 1;
  - fwd_rd_i[k] = rs[n];
  - rs[n] != 0.
  - Register 0 is never forwarded and never causes a hazard.
- Operand select:
  - Lowest matching k wins.
  - If no stage matches, use id_data_i[n].
  - Selection is combinational; the result is registered.
- Hazard for operand n, either of:
  - the EX register holds a valid load (ex_valid_o & ex_we_o & ex_ld_o) with ex_rd_o = rs[n] != 0;
  - the winning producer k has fwd_pend_i[k] = 1.
  - An older non-pending match does not mask a younger pending one.
- hazard = id_valid_i & OR of operand hazards.
- stall_o = hazard | hold_i (combinational).
- Clock-edge priority, highest first:
  - rst_i: clear everything.
  - hold_i: all EX registers keep their value.
  - flush_i: ex_valid_o <= 0, ex_we_o <= 0, ex_ld_o <= 0. Data and rd are don't-care.
  - hazard: bubble. ex_valid_o/ex_we_o/ex_ld_o <= 0; ID is re-presented next cycle by upstream.
  - Otherwise: capture id_valid_i, the selected operands, id_rd_i, and id_we_i & id_valid_i, id_ld_i & id_valid_i.
- Latency: 1 cycle from ID to EX.
- Load-use:
  - A load followed immediately by a dependent instruction gives exactly 1 bubble, provided the producer k=0 stage clears fwd_pend_i next cycle.
  - Each further pending cycle adds one bubble.
- Invalid ID (id_valid_i = 0): no hazard, no stall; a bubble is captured.
- Reset mid-stall: all state clears; stall_o then depends only on the current inputs.

Optional Feature:
- Macro FWD_STAT_EN.
- Defined:
  - fwd_cnt_o increments by the number of operands actually forwarded (0..NUM_SRC) on each capture edge: not hold, not flush, not hazard, id_valid_i = 1.
  - stall_cnt_o increments by 1 on each edge where hazard = 1 and hold_i = 0.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- EX/MEM forward: fwd_we_i=2'b01, fwd_rd_i[0]=5'd3, fwd_data_i[0]=32'hAAAA0001, rs[0]=3, id_data=0 -> next cycle ex_data_o[0]=32'hAAAA0001, ex_valid_o=1, stall_o=0.
- Priority: both stages write r7, stage0 data=32'h11, stage1 data=32'h22, rs[1]=7 -> ex_data_o[1]=32'h11. Same setup with rs[1]=0 -> ex_data_o[1] = id_data_i[1].
- Load-use: cycle 1 load r5 (id_ld_i=1, id_we_i=1); cycle 2 instruction with rs[0]=5 -> stall_o=1 in cycle 2 and ex_valid_o=0 after the edge. Cycle 3 with fwd_rd_i[0]=5, fwd_pend_i=0, data=32'h55 -> ex_data_o[0]=32'h55, stall_o=0.
- Hold vs flush: EX holds valid data 32'h1234, assert hold_i=1 and flush_i=1 together -> EX unchanged, stall_o=1. Release hold with flush_i=1 -> ex_valid_o=0.
- Reset mid-stall: assert rst_i while hazard stall is active -> all outputs 0 next cycle, counters 0.
- FWD_STAT_EN: 3 dual-forward captures plus 1 load-use stall -> fwd_cnt_o=6, stall_cnt_o=1. Without the macro both read 0.
